// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the processor datapath.
// Sequences FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and UPDATE_PC for each
// instruction. It also provides a registered opcode, a data-memory handshake
// with timeout, branch/CMOV condition capture, a resumable HALTED state, a
// sticky FAULT state and a retired-instruction counter.
//
// Handshakes: instr_valid is a level qualifier looked at only in FETCH; the
// cycle it is seen high, the instruction register loads (IRload) and the FSM
// moves on. mem_req is held high for every MEMORY cycle. The access completes
// in the first MEMORY cycle where mem_ready is seen high. resume is looked at
// only in HALTED. Outside those states these inputs are don't-care.
module multicycle_ctrl_fsm #(
    parameter int OPW         = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  op_code,
    input  logic            instr_valid,
    input  logic            mem_ready,
    input  logic            flag_n,
    input  logic            flag_z,
    input  logic            resume,
    output logic            loadPC,
    output logic            IRload,
    output logic            MemRW,
    output logic            mem_req,
    output logic            IMMsel,
    output logic [1:0]      DataSel,
    output logic [2:0]      BRANCH,
    output logic            RegWrite,
    output logic            halted,
    output logic            error,
    output logic [2:0]      state,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_UPDATE_PC = 3'd5,
        S_HALTED    = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    // Low-nibble opcode map; A-D are unassigned and therefore illegal.
    localparam logic [3:0] OP_ALU     = 4'h0;
    localparam logic [3:0] OP_ALU_IMM = 4'h1;
    localparam logic [3:0] OP_LOAD    = 4'h2;
    localparam logic [3:0] OP_STORE   = 4'h3;
    localparam logic [3:0] OP_BR      = 4'h4;
    localparam logic [3:0] OP_BMI     = 4'h5;
    localparam logic [3:0] OP_BPL     = 4'h6;
    localparam logic [3:0] OP_BZ      = 4'h7;
    localparam logic [3:0] OP_MOVE    = 4'h8;
    localparam logic [3:0] OP_CMOV    = 4'h9;
    localparam logic [3:0] OP_NOP     = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    // wait_cnt counts completed MEMORY cycles without mem_ready. It is wide
    // enough to hold MEM_TIMEOUT-1, and it saturates when the timeout is disabled.
    localparam int             WCW       = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WCW-1:0] LAST_WAIT = WCW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic [WCW-1:0] WAIT_MAX  = '1;
    localparam bit             TIMEOUT_ON = (MEM_TIMEOUT > 0);

    state_t          cur;
    logic [OPW-1:0]  opcode_reg;
    logic            cond_reg;
    logic [WCW-1:0]  wait_cnt;

    logic [3:0]      op_lo;
    logic            op_upper_clear;
    logic            op_legal;
    logic            op_is_branch;
    logic            cond_next;
    logic            mem_expired;

    assign op_lo = opcode_reg[3:0];

    // Any set bit above bit 3 makes the opcode illegal.
    generate
        if (OPW > 4) begin : g_upper
            assign op_upper_clear = ~|opcode_reg[OPW-1:4];
        end else begin : g_no_upper
            assign op_upper_clear = 1'b1;
        end
    endgenerate

    assign op_legal     = op_upper_clear && ((op_lo <= OP_CMOV) || (op_lo >= OP_NOP));
    assign op_is_branch = (op_lo[3:2] == 2'b01);
    assign mem_expired  = TIMEOUT_ON && (wait_cnt == LAST_WAIT);
    assign state        = cur;

    // Condition captured at the end of EXECUTE: the branch predicate, or flag_n for CMOV.
    always_comb begin
        cond_next = 1'b0;
        case (op_lo)
            OP_BR:   cond_next = 1'b1;
            OP_BMI:  cond_next = flag_n;
            OP_BPL:  cond_next = ~flag_n;
            OP_BZ:   cond_next = flag_z;
            OP_CMOV: cond_next = flag_n;
            default: cond_next = 1'b0;
        endcase
    end

    // State sequencing plus the opcode, condition, wait and retire registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_FETCH;
            opcode_reg  <= OPW'(OP_NOP);
            cond_reg    <= 1'b0;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            case (cur)
                S_FETCH: begin
                    if (instr_valid) begin
                        cur <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opcode_reg <= op_code;
                    cur        <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    cond_reg <= cond_next;
                    if (!op_legal) begin
                        cur <= S_FAULT;
                    end else begin
                        case (op_lo)
                            OP_ALU, OP_ALU_IMM, OP_MOVE, OP_CMOV: cur <= S_WRITEBACK;
                            OP_LOAD, OP_STORE: begin
                                cur      <= S_MEMORY;
                                wait_cnt <= '0;
                            end
                            OP_HALT: cur <= S_HALTED;
                            // Branches and NOP go straight to the PC update.
                            default: cur <= S_UPDATE_PC;
                        endcase
                    end
                end
                S_MEMORY: begin
                    // A ready in the final allowed cycle still completes normally.
                    if (mem_ready) begin
                        cur <= (op_lo == OP_LOAD) ? S_WRITEBACK : S_UPDATE_PC;
                    end else if (mem_expired) begin
                        cur <= S_FAULT;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                S_WRITEBACK: begin
                    cur <= S_UPDATE_PC;
                end
                S_UPDATE_PC: begin
                    instr_count <= instr_count + CNTW'(1);
                    cur         <= S_FETCH;
                end
                S_HALTED: begin
                    // On resume, the HALT itself retires through UPDATE_PC.
                    if (resume) begin
                        cur <= S_UPDATE_PC;
                    end
                end
                S_FAULT: begin
                    cur <= S_FAULT;
                end
                default: begin
                    cur <= S_FAULT;
                end
            endcase
        end
    end

    // Datapath controls decoded from the registered state, opcode and condition.
    always_comb begin
        loadPC   = 1'b0;
        IRload   = 1'b0;
        MemRW    = 1'b0;
        mem_req  = 1'b0;
        IMMsel   = 1'b0;
        DataSel  = 2'b00;
        BRANCH   = 3'b000;
        RegWrite = 1'b0;
        halted   = 1'b0;
        error    = 1'b0;
        case (cur)
            S_FETCH: begin
                IRload = instr_valid;
            end
            S_EXECUTE: begin
                IMMsel = (op_lo == OP_ALU_IMM);
            end
            S_MEMORY: begin
                mem_req = 1'b1;
                MemRW   = (op_lo == OP_STORE);
                DataSel = (op_lo == OP_LOAD) ? 2'b01 : 2'b00;
            end
            S_WRITEBACK: begin
                RegWrite = 1'b1;
                case (op_lo)
                    OP_ALU_IMM: IMMsel = 1'b1;
                    OP_LOAD:    DataSel = 2'b01;
                    OP_CMOV: begin
                        DataSel  = 2'b10;
                        RegWrite = cond_reg;
                    end
                    default: DataSel = 2'b00;
                endcase
            end
            S_UPDATE_PC: begin
                loadPC = 1'b1;
                // Branch codes 001..100 line up with opcodes 4..7 minus three.
                if (op_is_branch && cond_reg) begin
                    BRANCH = op_lo[2:0] - 3'd3;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                error = 1'b1;
            end
            default: begin
                loadPC = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm.
// A spec-level trace model builds the expected per-cycle outputs of each
// instruction from its opcode class, its fetch stall, its memory wait and its
// halt length. A second instance (OPW=5, CNTW=2, MEM_TIMEOUT=3) covers the
// upper-opcode-bit illegality, the counter wrap and a short timeout.
module tb_multicycle_ctrl_fsm;

    localparam logic Z = 1'b0;
    localparam logic O = 1'b1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [3:0]  op_code = 4'h0;
    logic        op_hi = 1'b0;
    logic        instr_valid = 1'b0, mem_ready = 1'b0, flag_n = 1'b0, flag_z = 1'b0, resume = 1'b0;

    logic        loadPC, IRload, MemRW, mem_req, IMMsel, RegWrite, halted, error;
    logic [1:0]  DataSel;
    logic [2:0]  BRANCH, state;
    logic [15:0] instr_count;

    logic        s_loadPC, s_IRload, s_MemRW, s_mem_req, s_IMMsel, s_RegWrite, s_halted, s_error;
    logic [1:0]  s_DataSel;
    logic [2:0]  s_BRANCH, s_state;
    logic [1:0]  s_instr_count;
    logic [4:0]  s_op;
    assign s_op = {op_hi, op_code};

    multicycle_ctrl_fsm #(.OPW(4), .MEM_TIMEOUT(15), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .flag_n(flag_n), .flag_z(flag_z), .resume(resume),
        .loadPC(loadPC), .IRload(IRload), .MemRW(MemRW), .mem_req(mem_req),
        .IMMsel(IMMsel), .DataSel(DataSel), .BRANCH(BRANCH), .RegWrite(RegWrite),
        .halted(halted), .error(error), .state(state), .instr_count(instr_count)
    );

    multicycle_ctrl_fsm #(.OPW(5), .MEM_TIMEOUT(3), .CNTW(2)) dut_small (
        .clk(clk), .reset(reset), .op_code(s_op), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .flag_n(flag_n), .flag_z(flag_z), .resume(resume),
        .loadPC(s_loadPC), .IRload(s_IRload), .MemRW(s_MemRW), .mem_req(s_mem_req),
        .IMMsel(s_IMMsel), .DataSel(s_DataSel), .BRANCH(s_BRANCH), .RegWrite(s_RegWrite),
        .halted(s_halted), .error(s_error), .state(s_state), .instr_count(s_instr_count)
    );

    logic [15:0] obs;
    assign obs = {state, loadPC, IRload, MemRW, mem_req, IMMsel, DataSel, BRANCH, RegWrite, halted, error};

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];
    logic [4:0]  in_q[$];
    logic [3:0]  op_q[$];
    logic [15:0] model_count = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] mk(input logic [2:0] st, input logic lp, input logic ir,
                                       input logic mw, input logic mq, input logic imm,
                                       input logic [1:0] ds, input logic [2:0] br,
                                       input logic rg, input logic hl, input logic er);
        return {st, lp, ir, mw, mq, imm, ds, br, rg, hl, er};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] ro();
        return 4'($urandom_range(0, 15));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input logic [15:0] e, input logic iv, input logic mr, input logic rs,
                        input logic fn, input logic fz, input logic [3:0] op);
        exp_q.push_back(e);
        in_q.push_back({iv, mr, rs, fn, fz});
        op_q.push_back(op);
    endtask

    // FETCH (d stall cycles, then the load cycle), DECODE, EXECUTE.
    task automatic plan_prefix(input logic [3:0] op, input logic fn, input logic fz, input int d);
        for (int i = 0; i < d; i++)
            push(mk(3'd0, Z, Z, Z, Z, Z, 2'b00, 3'b000, Z, Z, Z), Z, rb(), rb(), rb(), rb(), ro());
        push(mk(3'd0, Z, O, Z, Z, Z, 2'b00, 3'b000, Z, Z, Z), O, rb(), rb(), rb(), rb(), ro());
        push(mk(3'd1, Z, Z, Z, Z, Z, 2'b00, 3'b000, Z, Z, Z), rb(), rb(), rb(), rb(), rb(), op);
        push(mk(3'd2, Z, Z, Z, Z, (op == 4'h1), 2'b00, 3'b000, Z, Z, Z), rb(), rb(), rb(), fn, fz, ro());
    endtask

    // Whole retiring instruction: w = MEMORY cycles (ready on the last), h = HALTED cycles.
    task automatic plan_instr(input logic [3:0] op, input int d, input int w, input int h,
                              input logic fn, input logic fz);
        logic       taken;
        logic [2:0] br;
        logic [1:0] ds;
        plan_prefix(op, fn, fz, d);
        if (op == 4'h2 || op == 4'h3)
            for (int i = 0; i < w; i++)
                push(mk(3'd3, Z, Z, (op == 4'h3), O, Z, (op == 4'h2) ? 2'b01 : 2'b00, 3'b000, Z, Z, Z),
                     rb(), (i == w - 1), rb(), rb(), rb(), ro());
        if (op == 4'hF)
            for (int i = 0; i < h; i++)
                push(mk(3'd6, Z, Z, Z, Z, Z, 2'b00, 3'b000, Z, O, Z), rb(), rb(), (i == h - 1), rb(), rb(), ro());
        if (op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'h8 || op == 4'h9) begin
            ds = (op == 4'h9) ? 2'b10 : ((op == 4'h2) ? 2'b01 : 2'b00);
            push(mk(3'd4, Z, Z, Z, Z, (op == 4'h1), ds, 3'b000, (op == 4'h9) ? fn : O, Z, Z),
                 rb(), rb(), rb(), rb(), rb(), ro());
        end
        case (op)
            4'h4: begin taken = O;   br = 3'b001; end
            4'h5: begin taken = fn;  br = 3'b010; end
            4'h6: begin taken = ~fn; br = 3'b011; end
            4'h7: begin taken = fz;  br = 3'b100; end
            default: begin taken = Z; br = 3'b000; end
        endcase
        push(mk(3'd5, O, Z, Z, Z, Z, 2'b00, taken ? br : 3'b000, Z, Z, Z), rb(), rb(), rb(), rb(), rb(), ro());
    endtask

    // Apply queued cycles; lat = index of the loadPC cycle (1-based).
    task automatic run_plan(input bit retire, output int lat, output logic [2:0] br_seen, output logic rw_seen);
        logic [15:0] e;
        int idx = 0;
        lat = 0; br_seen = 3'b000; rw_seen = Z;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            {instr_valid, mem_ready, resume, flag_n, flag_z} = in_q.pop_front();
            op_code = op_q.pop_front();
            @(negedge clk);
            idx++;
            check("trace", 64'({obs, instr_count}), 64'({e, model_count}));
            if (loadPC) begin lat = idx; br_seen = BRANCH; end
            if (state == 3'd4) rw_seen = RegWrite;
            @(posedge clk); #1;
        end
        if (retire) model_count++;
    endtask

    task automatic do_reset();
        logic iv;
        reset = O;
        op_hi = Z;
        {instr_valid, mem_ready, resume, flag_n, flag_z} = 5'($urandom);
        op_code = ro();
        @(posedge clk); #1;
        iv = rb();
        instr_valid = iv;
        @(negedge clk);
        check("reset", 64'({obs, instr_count}), 64'({mk(3'd0, Z, iv, Z, Z, Z, 2'b00, 3'b000, Z, Z, Z), 16'h0}));
        check("small_reset", 64'({s_state, s_error, s_halted, s_instr_count}), 64'(0));
        @(posedge clk); #1;
        reset = Z;
        model_count = '0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] op;
        logic       fn;
        logic       fz;
        int         w;
        int         h;
        int         lat;
        logic [2:0] br;
        logic       rw;
    } vec_t;

    vec_t       vecs[19];
    logic [3:0] legal_ops[12];
    logic [1:0] cnt_seq[5];

    int          lat;
    logic [2:0]  br;
    logic        rw;
    logic [3:0]  rop;

    initial begin
        vecs[0]  = '{4'h0, Z, Z, 1, 1, 5,  3'b000, O};  // ALU
        vecs[1]  = '{4'h1, Z, Z, 1, 1, 5,  3'b000, O};  // ALU_IMM
        vecs[2]  = '{4'h2, Z, Z, 4, 1, 9,  3'b000, O};  // LOAD, 3 wait cycles
        vecs[3]  = '{4'h2, Z, Z, 1, 1, 6,  3'b000, O};  // LOAD, immediate ready
        vecs[4]  = '{4'h3, Z, Z, 1, 1, 5,  3'b000, Z};  // STORE
        vecs[5]  = '{4'h4, Z, Z, 1, 1, 4,  3'b001, Z};  // BR
        vecs[6]  = '{4'h5, O, Z, 1, 1, 4,  3'b010, Z};  // BMI taken
        vecs[7]  = '{4'h5, Z, Z, 1, 1, 4,  3'b000, Z};  // BMI not taken
        vecs[8]  = '{4'h6, Z, O, 1, 1, 4,  3'b011, Z};  // BPL taken
        vecs[9]  = '{4'h6, O, Z, 1, 1, 4,  3'b000, Z};  // BPL not taken
        vecs[10] = '{4'h7, Z, O, 1, 1, 4,  3'b100, Z};  // BZ taken
        vecs[11] = '{4'h7, O, Z, 1, 1, 4,  3'b000, Z};  // BZ not taken
        vecs[12] = '{4'h8, Z, Z, 1, 1, 5,  3'b000, O};  // MOVE
        vecs[13] = '{4'h9, O, Z, 1, 1, 5,  3'b000, O};  // CMOV, flag_n=1
        vecs[14] = '{4'h9, Z, O, 1, 1, 5,  3'b000, Z};  // CMOV, flag_n=0
        vecs[15] = '{4'hE, Z, Z, 1, 1, 4,  3'b000, Z};  // NOP
        vecs[16] = '{4'hF, Z, Z, 1, 10, 14, 3'b000, Z}; // HALT for 10 cycles
        vecs[17] = '{4'h3, Z, Z, 15, 1, 19, 3'b000, Z}; // STORE, ready in last allowed cycle
        vecs[18] = '{4'h2, Z, Z, 15, 1, 20, 3'b000, O}; // LOAD, ready in last allowed cycle
        legal_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE, 4'hF};
        cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset();

        // Table-driven instructions.
        for (int i = 0; i < 19; i++) begin
            plan_instr(vecs[i].op, 0, vecs[i].w, vecs[i].h, vecs[i].fn, vecs[i].fz);
            run_plan(1'b1, lat, br, rw);
            check("latency", 64'(lat), 64'(vecs[i].lat));
            check("branch", 64'(br), 64'(vecs[i].br));
            check("regwrite", 64'(rw), 64'(vecs[i].rw));
        end

        // STORE with no ready: 15 MEMORY cycles, then sticky FAULT for 21 cycles.
        do_reset();
        plan_prefix(4'h3, rb(), rb(), 0);
        for (int i = 0; i < 15; i++)
            push(mk(3'd3, Z, Z, O, O, Z, 2'b00, 3'b000, Z, Z, Z), rb(), Z, rb(), rb(), rb(), ro());
        for (int i = 0; i < 21; i++)
            push(mk(3'd7, Z, Z, Z, Z, Z, 2'b00, 3'b000, Z, Z, O), rb(), rb(), rb(), rb(), rb(), ro());
        run_plan(1'b0, lat, br, rw);
        do_reset();

        // Illegal opcode A faults straight from EXECUTE.
        plan_prefix(4'hA, rb(), rb(), 1);
        for (int i = 0; i < 5; i++)
            push(mk(3'd7, Z, Z, Z, Z, Z, 2'b00, 3'b000, Z, Z, O), rb(), rb(), rb(), rb(), rb(), ro());
        run_plan(1'b0, lat, br, rw);
        do_reset();

        // Retire one instruction, then reset from HALTED clears the count as well.
        plan_instr(4'hE, 0, 1, 1, rb(), rb());
        run_plan(1'b1, lat, br, rw);
        plan_prefix(4'hF, rb(), rb(), 0);
        for (int i = 0; i < 3; i++)
            push(mk(3'd6, Z, Z, Z, Z, Z, 2'b00, 3'b000, Z, O, Z), rb(), rb(), Z, rb(), rb(), ro());
        run_plan(1'b0, lat, br, rw);
        do_reset();

        // A 2-bit counter wraps over five NOPs.
        for (int i = 0; i < 5; i++) begin
            plan_instr(4'hE, $urandom_range(0, 2), 1, 1, rb(), rb());
            run_plan(1'b1, lat, br, rw);
            check("small_count", 64'(s_instr_count), 64'(cnt_seq[i]));
        end

        // Opcode bit 4 set: the OPW=5 instance faults while the main one runs ALU.
        do_reset();
        op_hi = O;
        plan_instr(4'h0, 0, 1, 1, rb(), rb());
        run_plan(1'b1, lat, br, rw);
        op_hi = Z;
        check("small_upper_fault", 64'({s_state, s_error}), 64'({3'd7, O}));

        // Timeout 3: ready in the 3rd MEMORY cycle wins; ready in the 4th is too late.
        do_reset();
        plan_instr(4'h3, 0, 3, 1, rb(), rb());
        run_plan(1'b1, lat, br, rw);
        check("small_ready_wins", 64'({s_state, s_error, s_instr_count}), 64'({3'd0, Z, 2'd1}));
        do_reset();
        plan_instr(4'h3, 0, 4, 1, rb(), rb());
        run_plan(1'b1, lat, br, rw);
        check("small_timeout", 64'({s_state, s_error}), 64'({3'd7, O}));

        // Randomized instruction stream against the trace model.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            rop = legal_ops[$urandom_range(0, 11)];
            plan_instr(rop, $urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(1, 3), rb(), rb());
            run_plan(1'b1, lat, br, rw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Cycle-budget guard so a stuck run still terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
